lsb_queue: RTL and testbench

- Parametrised in-order load/store queue for the Tomasulo RISC-V core. Sits between dispatcher, ROB, CDB and the memory controller.
- Depth, tag width and CDB channel count are parameters.
- Snoops N CDB channels for operands. Issues loads at the queue head speculatively. Issues stores only after ROB commit.
- Keeps committed stores across a mispredict flush.

---
 rtl/lsb_queue.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_lsb_queue.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsb_queue.sv
// lsb_queue: in-order load/store queue for the Tomasulo RISC-V core.
//   Loads issue speculatively from the queue head. Stores issue only after the
//   ROB commits them. Committed stores survive a mispredict flush.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable (low freezes state and outputs)
//   flush               mispredict flush
//   disp_*              dispatch request and operands; full = no free entry
//   cdb_valid/tag/data  NCDB packed result-broadcast channels (operand wakeup)
//   commit_valid/tag    ROB commit pulse
//   mem_*               memory request/response handshake (held until mem_done)
//   out_valid/tag/data  one-cycle load result, sign/zero extended
module lsb_queue #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 5,
  parameter int NCDB  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    flush,
  input  logic                    disp_valid,
  input  logic                    disp_store,
  input  logic [2:0]              disp_funct3,
  input  logic [31:0]             disp_imm,
  input  logic [TAG_W-1:0]        disp_tag,
  input  logic [TAG_W-1:0]        disp_qi,
  input  logic [TAG_W-1:0]        disp_qj,
  input  logic [31:0]             disp_vi,
  input  logic [31:0]             disp_vj,
  output logic                    full,
  input  logic [NCDB-1:0]         cdb_valid,
  input  logic [NCDB*TAG_W-1:0]   cdb_tag,
  input  logic [NCDB*32-1:0]      cdb_data,
  input  logic                    commit_valid,
  input  logic [TAG_W-1:0]        commit_tag,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  output logic [1:0]              mem_size,
  input  logic                    mem_done,
  input  logic [31:0]             mem_rdata,
  output logic                    out_valid,
  output logic [TAG_W-1:0]        out_tag,
  output logic [31:0]             out_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  // Resolve one operand against all CDB channels; tag 0 never matches.
  function automatic logic [TAG_W+31:0] snoop(
    input logic [TAG_W-1:0]      q,
    input logic [31:0]           v,
    input logic [NCDB-1:0]       cv,
    input logic [NCDB*TAG_W-1:0] ct,
    input logic [NCDB*32-1:0]    cd
  );
    logic [TAG_W-1:0] q_n;
    logic [31:0]      v_n;
    q_n = q;
    v_n = v;
    for (int c = 0; c < NCDB; c++) begin
      if (cv[c] && (q != {TAG_W{1'b0}}) && (ct[c*TAG_W +: TAG_W] == q)) begin
        q_n = {TAG_W{1'b0}};
        v_n = cd[c*32 +: 32];
      end else begin
        q_n = q_n;
        v_n = v_n;
      end
    end
    return {q_n, v_n};
  endfunction

  // Load data extension selected by funct3.
  function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [31:0] r);
    logic [31:0] d;
    case (f3)
      3'b000:  d = {{24{r[7]}}, r[7:0]};
      3'b001:  d = {{16{r[15]}}, r[15:0]};
      3'b100:  d = {24'h000000, r[7:0]};
      3'b101:  d = {16'h0000, r[15:0]};
      default: d = r;
    endcase
    return d;
  endfunction

  // Queue storage
  logic [DEPTH-1:0] valid_r, store_r, committed_r;
  logic [2:0]       funct3_r [DEPTH];
  logic [31:0]      imm_r    [DEPTH];
  logic [TAG_W-1:0] tag_r    [DEPTH];
  logic [TAG_W-1:0] qi_r     [DEPTH];
  logic [TAG_W-1:0] qj_r     [DEPTH];
  logic [31:0]      vi_r     [DEPTH];
  logic [31:0]      vj_r     [DEPTH];

  logic [PTR_W-1:0] head_r, tail_r, head_n_s, tail_n_s;
  logic [CNT_W-1:0] count_r, count_n_s, kept_s;
  logic             full_r;

  state_t           state_r;
  logic             suppress_r;
  logic             mem_req_r, mem_we_r, out_valid_r;
  logic [31:0]      mem_addr_r, mem_wdata_r, out_data_r;
  logic [1:0]       mem_size_r;
  logic [TAG_W-1:0] out_tag_r;

  // Combinational wakeup / commit / control
  logic [TAG_W-1:0] wk_qi_s [DEPTH];
  logic [TAG_W-1:0] wk_qj_s [DEPTH];
  logic [31:0]      wk_vi_s [DEPTH];
  logic [31:0]      wk_vj_s [DEPTH];
  logic [DEPTH-1:0] commit_hit_s, keep_s;
  logic [TAG_W-1:0] d_qi_s, d_qj_s;
  logic [31:0]      d_vi_s, d_vj_s;
  logic             head_ready_s, retire_s, flush_s, issue_s, accept_s;

  // Operand wakeup for stored entries and for the entry being dispatched.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {wk_qi_s[i], wk_vi_s[i]} = snoop(qi_r[i], vi_r[i], cdb_valid, cdb_tag, cdb_data);
      {wk_qj_s[i], wk_vj_s[i]} = snoop(qj_r[i], vj_r[i], cdb_valid, cdb_tag, cdb_data);
      commit_hit_s[i] = commit_valid && valid_r[i] && store_r[i] && (tag_r[i] == commit_tag);
    end
    {d_qi_s, d_vi_s} = snoop(disp_qi, disp_vi, cdb_valid, cdb_tag, cdb_data);
    {d_qj_s, d_vj_s} = snoop(disp_qj, disp_vj, cdb_valid, cdb_tag, cdb_data);
  end

  // Head readiness and the per-cycle control strobes.
  always_comb begin
    if (!valid_r[head_r] || (qi_r[head_r] != {TAG_W{1'b0}})) begin
      head_ready_s = 1'b0;
    end else if (store_r[head_r]) begin
      head_ready_s = (qj_r[head_r] == {TAG_W{1'b0}}) && committed_r[head_r];
    end else begin
      head_ready_s = 1'b1;
    end
    retire_s = rdy && (state_r == ST_BUSY) && mem_done;
    flush_s  = rdy && flush;
    issue_s  = rdy && !flush && (state_r == ST_IDLE) && head_ready_s;
    // A full queue can still take a dispatch when the head retires this cycle.
    accept_s = rdy && !flush && disp_valid && (!full_r || retire_s);
  end

  // Flush survivors: the in-flight head plus the committed stores contiguous
  // behind it. Same-cycle commits count, so a store committed as the flush
  // arrives is kept.
  always_comb begin
    logic [PTR_W-1:0] idx_v;
    logic             run_v;
    keep_s = {DEPTH{1'b0}};
    kept_s = {CNT_W{1'b0}};
    run_v  = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      idx_v = head_r + PTR_W'(k);
      if (run_v && valid_r[idx_v] &&
          (((idx_v == head_r) && (state_r == ST_BUSY)) ||
           (store_r[idx_v] && (committed_r[idx_v] || commit_hit_s[idx_v])))) begin
        keep_s[idx_v] = 1'b1;
        kept_s        = kept_s + CNT_W'(1);
      end else begin
        run_v = 1'b0;
      end
    end
  end

  // Next head / tail / count.
  always_comb begin
    head_n_s = head_r + PTR_W'(retire_s);
    if (flush_s) begin
      tail_n_s  = head_r + kept_s[PTR_W-1:0];
      count_n_s = kept_s - CNT_W'(retire_s);
    end else begin
      tail_n_s  = tail_r + PTR_W'(accept_s);
      count_n_s = count_r + CNT_W'(accept_s) - CNT_W'(retire_s);
    end
  end

  // Pointers, occupancy and entry storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r      <= {PTR_W{1'b0}};
      tail_r      <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      full_r      <= 1'b0;
      valid_r     <= {DEPTH{1'b0}};
      store_r     <= {DEPTH{1'b0}};
      committed_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        funct3_r[i] <= 3'b000;
        imm_r[i]    <= 32'h0000_0000;
        tag_r[i]    <= {TAG_W{1'b0}};
        qi_r[i]     <= {TAG_W{1'b0}};
        qj_r[i]     <= {TAG_W{1'b0}};
        vi_r[i]     <= 32'h0000_0000;
        vj_r[i]     <= 32'h0000_0000;
      end
    end else if (rdy) begin
      head_r  <= head_n_s;
      tail_r  <= tail_n_s;
      count_r <= count_n_s;
      full_r  <= (count_n_s == CNT_W'(DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_s) begin
          valid_r[i] <= keep_s[i] && !(retire_s && (PTR_W'(i) == head_r));
        end else if (accept_s && (PTR_W'(i) == tail_r)) begin
          valid_r[i] <= 1'b1;
        end else if (retire_s && (PTR_W'(i) == head_r)) begin
          valid_r[i] <= 1'b0;
        end
        if (accept_s && (PTR_W'(i) == tail_r)) begin
          store_r[i]     <= disp_store;
          committed_r[i] <= 1'b0;
          funct3_r[i]    <= disp_funct3;
          imm_r[i]       <= disp_imm;
          tag_r[i]       <= disp_tag;
          qi_r[i]        <= d_qi_s;
          qj_r[i]        <= d_qj_s;
          vi_r[i]        <= d_vi_s;
          vj_r[i]        <= d_vj_s;
        end else begin
          committed_r[i] <= committed_r[i] | commit_hit_s[i];
          qi_r[i]        <= wk_qi_s[i];
          qj_r[i]        <= wk_qj_s[i];
          vi_r[i]        <= wk_vi_s[i];
          vj_r[i]        <= wk_vj_s[i];
        end
      end
    end
  end

  // Memory FSM with registered request and load-result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      suppress_r  <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      mem_size_r  <= 2'b00;
      out_valid_r <= 1'b0;
      out_tag_r   <= {TAG_W{1'b0}};
      out_data_r  <= 32'h0000_0000;
    end else if (rdy) begin
      out_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (issue_s) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= store_r[head_r];
            mem_addr_r  <= vi_r[head_r] + imm_r[head_r];
            mem_wdata_r <= vj_r[head_r];
            mem_size_r  <= funct3_r[head_r][1:0];
            suppress_r  <= 1'b0;
            state_r     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (mem_done) begin
            mem_req_r  <= 1'b0;
            suppress_r <= 1'b0;
            state_r    <= ST_IDLE;
            // A load flushed while in flight still completes but reports nothing.
            if (!store_r[head_r] && !suppress_r && !flush) begin
              out_valid_r <= 1'b1;
              out_tag_r   <= tag_r[head_r];
              out_data_r  <= ext_load(funct3_r[head_r], mem_rdata);
            end
          end else if (flush && !store_r[head_r]) begin
            suppress_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign full      = full_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_size  = mem_size_r;
  assign out_valid = out_valid_r;
  assign out_tag   = out_tag_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_lsb_queue.sv
// Scoreboard bench for lsb_queue: stimulus pushes expected memory requests and
// load results into queues; a monitor pops and compares as the DUT presents them.
module tb_lsb_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int NCDB  = 2;

  logic clk, rst, rdy, flush;
  logic disp_valid, disp_store;
  logic [2:0] disp_funct3;
  logic [31:0] disp_imm, disp_vi, disp_vj;
  logic [TAG_W-1:0] disp_tag, disp_qi, disp_qj;
  logic full;
  logic [NCDB-1:0] cdb_valid;
  logic [NCDB*TAG_W-1:0] cdb_tag;
  logic [NCDB*32-1:0] cdb_data;
  logic commit_valid;
  logic [TAG_W-1:0] commit_tag;
  logic mem_req, mem_we, mem_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0] mem_size;
  logic out_valid;
  logic [TAG_W-1:0] out_tag;
  logic [31:0] out_data;

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [1:0] size;} req_t;
  typedef struct packed {logic [TAG_W-1:0] tag; logic [31:0] data;} res_t;

  req_t exp_req[$];
  res_t exp_res[$];
  req_t er;
  res_t eo;
  int checks = 0;
  int errors = 0;
  logic req_seen = 1'b0;

  lsb_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NCDB(NCDB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .disp_valid(disp_valid), .disp_store(disp_store), .disp_funct3(disp_funct3),
    .disp_imm(disp_imm), .disp_tag(disp_tag), .disp_qi(disp_qi), .disp_qj(disp_qj),
    .disp_vi(disp_vi), .disp_vj(disp_vj), .full(full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_tag(out_tag), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare each new memory request and each load result.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && !req_seen) begin
        req_seen = 1'b1;
        checks++;
        if (exp_req.size() == 0) begin
          errors++;
          $display("FAIL req_unexpected got we=%0d addr=%h wdata=%h size=%0d", mem_we, mem_addr, mem_wdata, mem_size);
        end else begin
          er = exp_req.pop_front();
          if ({mem_we, mem_addr, mem_wdata, mem_size} !== er) begin
            errors++;
            $display("FAIL mem_req got we=%0d addr=%h wdata=%h size=%0d expected we=%0d addr=%h wdata=%h size=%0d",
                     mem_we, mem_addr, mem_wdata, mem_size, er.we, er.addr, er.wdata, er.size);
          end
        end
      end
      if (!mem_req) req_seen = 1'b0;
      if (out_valid) begin
        checks++;
        if (exp_res.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected got tag=%0d data=%h", out_tag, out_data);
        end else begin
          eo = exp_res.pop_front();
          if ({out_tag, out_data} !== eo) begin
            errors++;
            $display("FAIL out_result got tag=%0d data=%h expected tag=%0d data=%h", out_tag, out_data, eo.tag, eo.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [1:0] size);
    exp_req.push_back({we, addr, wdata, size});
  endtask

  task automatic push_res(input logic [TAG_W-1:0] tag, input logic [31:0] data);
    exp_res.push_back({tag, data});
  endtask

  task automatic dispatch(input logic st, input logic [2:0] f3, input logic [31:0] imm,
                          input logic [TAG_W-1:0] tag, input logic [TAG_W-1:0] qi,
                          input logic [TAG_W-1:0] qj, input logic [31:0] vi, input logic [31:0] vj);
    disp_valid = 1'b1; disp_store = st; disp_funct3 = f3; disp_imm = imm;
    disp_tag = tag; disp_qi = qi; disp_qj = qj; disp_vi = vi; disp_vj = vj;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic commit(input logic [TAG_W-1:0] tag);
    commit_valid = 1'b1; commit_tag = tag;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!mem_req && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (!mem_req) begin
      errors++;
      $display("FAIL req_timeout got mem_req=0 expected 1 within 30 cycles");
    end
  endtask

  task automatic complete(input logic [31:0] rdata);
    wait_req();
    mem_rdata = rdata; mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    check("req_drop", 32'(mem_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    disp_valid = 1'b0; disp_store = 1'b0; disp_funct3 = 3'b000; disp_imm = 32'h0;
    disp_tag = 5'd0; disp_qi = 5'd0; disp_qj = 5'd0; disp_vi = 32'h0; disp_vj = 32'h0;
    cdb_valid = 2'b00; cdb_tag = 10'd0; cdb_data = 64'h0;
    commit_valid = 1'b0; commit_tag = 5'd0; mem_done = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_out_data", out_data, 32'h0);
    rst = 1'b0;
    tick();

    // LW: 0x100 + 4, raw word back.
    push_req(1'b0, 32'h104, 32'h0, 2'd2);
    push_res(5'd1, 32'hDEADBEEF);
    dispatch(1'b0, 3'b010, 32'd4, 5'd1, 5'd0, 5'd0, 32'h100, 32'h0);
    complete(32'hDEADBEEF);
    tick();
    check("out_valid_pulse", 32'(out_valid), 32'd0);

    // Byte / half extension.
    push_req(1'b0, 32'h10, 32'h0, 2'd0); push_res(5'd2, 32'hFFFFFF80);
    dispatch(1'b0, 3'b000, 32'd0, 5'd2, 5'd0, 5'd0, 32'h10, 32'h0);
    complete(32'h00000080);
    push_req(1'b0, 32'h10, 32'h0, 2'd0); push_res(5'd3, 32'h00000080);
    dispatch(1'b0, 3'b100, 32'd0, 5'd3, 5'd0, 5'd0, 32'h10, 32'h0);
    complete(32'h00000080);
    push_req(1'b0, 32'h20, 32'h0, 2'd1); push_res(5'd4, 32'hFFFF8001);
    dispatch(1'b0, 3'b001, 32'd0, 5'd4, 5'd0, 5'd0, 32'h20, 32'h0);
    complete(32'h00008001);
    push_req(1'b0, 32'h20, 32'h0, 2'd1); push_res(5'd5, 32'h00008001);
    dispatch(1'b0, 3'b101, 32'd0, 5'd5, 5'd0, 5'd0, 32'h20, 32'h0);
    complete(32'h12348001);
    tick();

    // SW waits for commit.
    push_req(1'b1, 32'h308, 32'hCAFEF00D, 2'd2);
    dispatch(1'b1, 3'b010, 32'd8, 5'd3, 5'd0, 5'd0, 32'h300, 32'hCAFEF00D);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("sw_wait_commit", 32'(mem_req), 32'd0);
    end
    commit(5'd3);
    tick();
    check("sw_req_after_commit", 32'(mem_req), 32'd1);
    check("sw_we", 32'(mem_we), 32'd1);
    complete(32'h0);
    tick();

    // CDB channel 1 wakes the base in the dispatch cycle.
    push_req(1'b0, 32'h210, 32'h0, 2'd2); push_res(5'd6, 32'h55);
    cdb_valid = 2'b10; cdb_tag = {5'd7, 5'd0}; cdb_data = {32'h200, 32'h0};
    dispatch(1'b0, 3'b010, 32'h10, 5'd6, 5'd7, 5'd0, 32'h0, 32'h0);
    cdb_valid = 2'b00;
    tick();
    check("cdb_no_stall", 32'(mem_req), 32'd1);
    complete(32'h55);
    tick();

    // Stored entry woken later by channel 0.
    push_req(1'b0, 32'h404, 32'h0, 2'd2); push_res(5'd7, 32'h66);
    dispatch(1'b0, 3'b010, 32'd4, 5'd7, 5'd9, 5'd0, 32'h0, 32'h0);
    tick(); tick();
    check("wait_operand", 32'(mem_req), 32'd0);
    cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd9}; cdb_data = {32'h0, 32'h400};
    tick();
    cdb_valid = 2'b00;
    complete(32'h66);
    tick();

    // Fill, drop extra, swap at full.
    for (int k = 0; k < 4; k++) push_req(1'b1, 32'h1000 + 32'(16 * k), 32'(k + 1), 2'd2);
    push_req(1'b1, 32'h1100, 32'h15, 2'd2);
    check("not_full_empty", 32'(full), 32'd0);
    for (int k = 0; k < 4; k++) begin
      dispatch(1'b1, 3'b010, 32'd0, TAG_W'(10 + k), 5'd0, 5'd0, 32'h1000 + 32'(16 * k), 32'(k + 1));
      if (k == 2) check("not_full_depth_m1", 32'(full), 32'd0);
    end
    check("full_at_depth", 32'(full), 32'd1);
    dispatch(1'b1, 3'b010, 32'd0, 5'd14, 5'd0, 5'd0, 32'hBAD, 32'hBAD);
    check("full_after_drop", 32'(full), 32'd1);
    commit(5'd10);
    wait_req();
    mem_done = 1'b1;
    dispatch(1'b1, 3'b010, 32'd0, 5'd15, 5'd0, 5'd0, 32'h1100, 32'h15);
    mem_done = 1'b0;
    check("full_after_swap", 32'(full), 32'd1);
    commit(5'd11); commit(5'd12); commit(5'd13); commit(5'd15);
    for (int k = 0; k < 4; k++) complete(32'h0);
    tick();
    check("drained_not_full", 32'(full), 32'd0);

    // Flush during committed SW: SW completes, LW/SB discarded.
    push_req(1'b1, 32'h2000, 32'hA5A5A5A5, 2'd2);
    dispatch(1'b1, 3'b010, 32'd0, 5'd20, 5'd0, 5'd0, 32'h2000, 32'hA5A5A5A5);
    commit(5'd20);
    dispatch(1'b0, 3'b010, 32'd0, 5'd21, 5'd0, 5'd0, 32'h3000, 32'h0);
    dispatch(1'b1, 3'b000, 32'd0, 5'd22, 5'd0, 5'd0, 32'h3004, 32'h11);
    wait_req();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    complete(32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("flush_empty_no_req", 32'(mem_req), 32'd0);
    end
    check("flush_not_full", 32'(full), 32'd0);
    push_req(1'b0, 32'h5000, 32'h0, 2'd2); push_res(5'd23, 32'h77);
    dispatch(1'b0, 3'b010, 32'd0, 5'd23, 5'd0, 5'd0, 32'h5000, 32'h0);
    complete(32'h77);
    tick();

    // Flush during an in-flight load: completes silently.
    push_req(1'b0, 32'h6000, 32'h0, 2'd2);
    dispatch(1'b0, 3'b010, 32'd0, 5'd24, 5'd0, 5'd0, 32'h6000, 32'h0);
    wait_req();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_load_busy", 32'(mem_req), 32'd1);
    complete(32'h99);
    check("flush_load_no_out", 32'(out_valid), 32'd0);
    tick();

    // Commit in the flush cycle keeps the store.
    push_req(1'b1, 32'h7000, 32'h42, 2'd2);
    dispatch(1'b1, 3'b010, 32'd0, 5'd25, 5'd0, 5'd0, 32'h7000, 32'h42);
    flush = 1'b1; commit_valid = 1'b1; commit_tag = 5'd25;
    tick();
    flush = 1'b0; commit_valid = 1'b0;
    complete(32'h0);
    tick();

    // Dispatch in the flush cycle is ignored.
    flush = 1'b1;
    dispatch(1'b0, 3'b010, 32'd0, 5'd26, 5'd0, 5'd0, 32'h8000, 32'h0);
    flush = 1'b0;
    tick(); tick();
    check("flush_disp_ignored", 32'(mem_req), 32'd0);

    tick(); tick();
    check("req_queue_empty", 32'(exp_req.size()), 32'd0);
    check("res_queue_empty", 32'(exp_res.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
